// File: rtl/scroll_banner_pkg.sv
// Shared constants and digit arithmetic for the scrolling decimal banner.
// Codes above 9 are treated as blank by both the increment and decrement rules.
package banner_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BLANK      = 4'hF;
    localparam logic [DIGIT_W-1:0] DIGIT_ZERO = 4'h0;
    localparam logic [DIGIT_W-1:0] DIGIT_NINE = 4'h9;

    typedef enum logic {
        DirRight = 1'b0,
        DirLeft  = 1'b1
    } dir_e;

    // Blank (or any non-decimal code) enters as 0, and 9 wraps to 0.
    function automatic logic [DIGIT_W-1:0] dig_inc(input logic [DIGIT_W-1:0] d);
        logic [DIGIT_W-1:0] r;
        if (d >= DIGIT_NINE) begin
            r = DIGIT_ZERO;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    // Blank (or any non-decimal code) enters as 9, and 0 wraps to 9.
    function automatic logic [DIGIT_W-1:0] dig_dec(input logic [DIGIT_W-1:0] d);
        logic [DIGIT_W-1:0] r;
        if ((d == DIGIT_ZERO) || (d > DIGIT_NINE)) begin
            r = DIGIT_NINE;
        end else begin
            r = d - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/scroll_banner_tick_gen.sv
// Scroll-rate prescaler: counts 0..TICK_CNT-1 while run is high and pulses tick on the
// terminal count; the count holds while run is low.
module tick_gen #(
    parameter int unsigned TICK_CNT = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int unsigned CntW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_CNT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            at_max;

    assign at_max = (cnt_q == CntMax);
    assign tick   = run & at_max;

    always_comb begin
        cnt_d = cnt_q;
        if (run) begin
            cnt_d = at_max ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scroll_banner.sv
// NUM_DIG-wide decimal scrolling banner: digits enter at one edge of the window, derived
// from the current edge digit, and the window shifts on prescaler ticks or paused steps.
module scroll_banner
    import banner_pkg::*;
#(
    parameter int unsigned NUM_DIG  = 4,
    parameter int unsigned TICK_CNT = 500000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       dir,
    input  logic                       step,
    input  logic                       clear,
    output logic [DIGIT_W*NUM_DIG-1:0] digits,
    output logic                       tick,
    output logic                       full
);

    logic [DIGIT_W-1:0] dig_q     [NUM_DIG];
    logic [DIGIT_W-1:0] left_src  [NUM_DIG];
    logic [DIGIT_W-1:0] right_src [NUM_DIG];
    logic [DIGIT_W-1:0] dig_d     [NUM_DIG];
    logic [NUM_DIG-1:0] not_blank;

    logic pre_tick;
    logic shift_en;
    logic tick_q, tick_d;

    tick_gen #(
        .TICK_CNT (TICK_CNT)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .run   (enable),
        .tick  (pre_tick)
    );

    // Step only counts while paused; in free-run the prescaler alone sets the rate.
    assign shift_en = pre_tick | (~enable & step);

    for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
        if (i == 0) begin : g_left_entry
            assign left_src[i] = dig_inc(dig_q[0]);
        end else begin : g_left_pass
            assign left_src[i] = dig_q[i-1];
        end

        if (i == NUM_DIG - 1) begin : g_right_entry
            assign right_src[i] = dig_dec(dig_q[NUM_DIG-1]);
        end else begin : g_right_pass
            assign right_src[i] = dig_q[i+1];
        end

        assign dig_d[i]                   = (dir_e'(dir) == DirLeft) ? left_src[i] : right_src[i];
        assign digits[DIGIT_W*i +: DIGIT_W] = dig_q[i];
        assign not_blank[i]               = (dig_q[i] != BLANK);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                dig_q[i] <= BLANK;
            end
        end else if (shift_en) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                dig_q[i] <= dig_d[i];
            end
        end
    end

    always_comb begin
        tick_d = shift_en & ~clear;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
    assign full = &not_blank;

endmodule

// File: tb/tb_scroll_banner.sv
// Bench for scroll_banner: three widths driven in parallel against a per-window model,
// directed scenarios pinned with literal windows, then a randomized soak.
module tb_scroll_banner;

    localparam int T = 3;

    logic        clk = 1'b0;
    logic        reset, enable, dir, step, clear;
    logic [15:0] dig4;
    logic [3:0]  dig1;
    logic [31:0] dig8;
    logic        tick4, tick1, tick8, full4, full1, full8;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    scroll_banner #(.NUM_DIG(4), .TICK_CNT(T)) u_dut4 (
        .clk(clk), .reset(reset), .enable(enable), .dir(dir), .step(step), .clear(clear),
        .digits(dig4), .tick(tick4), .full(full4));
    scroll_banner #(.NUM_DIG(1), .TICK_CNT(T)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .dir(dir), .step(step), .clear(clear),
        .digits(dig1), .tick(tick1), .full(full1));
    scroll_banner #(.NUM_DIG(8), .TICK_CNT(T)) u_dut8 (
        .clk(clk), .reset(reset), .enable(enable), .dir(dir), .step(step), .clear(clear),
        .digits(dig8), .tick(tick8), .full(full8));

    // Model: window as plain integers, 15 = blank; index 0 = rightmost digit.
    int md[3][8];
    int mcnt[3];
    bit mtick[3];

    function automatic int nd(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 8);
    endfunction

    always @(posedge clk) begin : model
        bit sh;
        int e;
        int n;
        for (int k = 0; k < 3; k++) begin
            n = nd(k);
            if (reset || clear) begin
                for (int i = 0; i < 8; i++) md[k][i] = 15;
                mcnt[k]  = 0;
                mtick[k] = 1'b0;
            end else begin
                sh = enable ? (mcnt[k] == T - 1) : step;
                if (enable) mcnt[k] = sh ? 0 : mcnt[k] + 1;
                if (sh) begin
                    if (dir) begin
                        e = (md[k][0] > 9) ? 0 : (md[k][0] + 1) % 10;
                        for (int i = n - 1; i >= 1; i--) md[k][i] = md[k][i-1];
                        md[k][0] = e;
                    end else begin
                        e = (md[k][n-1] > 9) ? 9 : (md[k][n-1] + 9) % 10;
                        for (int i = 0; i < n - 1; i++) md[k][i] = md[k][i+1];
                        md[k][n-1] = e;
                    end
                end
                mtick[k] = sh;
            end
        end
    end

    function automatic logic [31:0] mpack(input int k);
        logic [31:0] v = '0;
        for (int i = 0; i < nd(k); i++) v[4*i +: 4] = 4'(md[k][i]);
        return v;
    endfunction

    function automatic logic mfull(input int k);
        logic f = 1'b1;
        for (int i = 0; i < nd(k); i++) if (md[k][i] == 15) f = 1'b0;
        return f;
    endfunction

    function automatic logic nonblank_rule(input logic [31:0] v, input int n);
        logic f = 1'b1;
        for (int i = 0; i < n; i++) if (v[4*i +: 4] == 4'hF) f = 1'b0;
        return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("dig4", {16'h0, dig4}, mpack(0));
            chk("tick4", {31'h0, tick4}, {31'h0, mtick[0]});
            chk("full4", {31'h0, full4}, {31'h0, mfull(0)});
            chk("full4_rule", {31'h0, full4}, {31'h0, nonblank_rule({16'h0, dig4}, 4)});
            chk("dig1", {28'h0, dig1}, mpack(1));
            chk("tick1", {31'h0, tick1}, {31'h0, mtick[1]});
            chk("full1", {31'h0, full1}, {31'h0, mfull(1)});
            chk("dig8", dig8, mpack(2));
            chk("tick8", {31'h0, tick8}, {31'h0, mtick[2]});
            chk("full8", {31'h0, full8}, {31'h0, mfull(2)});
            chk("full8_rule", {31'h0, full8}, {31'h0, nonblank_rule(dig8, 8)});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Literal window check on the 4-digit DUT, also pinning the model.
    task automatic lit(input string nm, input logic [15:0] exp);
        chk({nm, "_dut"}, {16'h0, dig4}, {16'h0, exp});
        chk({nm, "_model"}, mpack(0), {16'h0, exp});
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b1; step = 1'b0; clear = 1'b0;
        cyc(1);
        lit("reset_window", 16'hFFFF);
        chk("reset_tick", {31'h0, tick4}, 32'h0);
        chk("reset_full", {31'h0, full4}, 32'h0);
        cyc(1);
        reset = 1'b0;
    endtask

    logic [15:0] seq_l[12] = '{16'hFFF0, 16'hFF01, 16'hF012, 16'h0123, 16'h1234, 16'h2345,
                               16'h3456, 16'h4567, 16'h5678, 16'h6789, 16'h7890, 16'h8901};
    logic [15:0] seq_r[12] = '{16'h9FFF, 16'h89FF, 16'h789F, 16'h6789, 16'h5678, 16'h4567,
                               16'h3456, 16'h2345, 16'h1234, 16'h0123, 16'h9012, 16'h8901};

    initial begin
        reset = 1'b1; enable = 1'b1; dir = 1'b1; step = 1'b0; clear = 1'b0;
        started = 1'b1;

        // Left fill from blanks, one tick per shift, then 9 -> 0 wrap at entry.
        do_reset();
        dir = 1'b1;
        for (int s = 0; s < 12; s++) begin
            cyc(T);
            lit("left_fill", seq_l[s]);
            chk("left_tick", {31'h0, tick4}, 32'h1);
        end
        cyc(T);
        lit("left_wrap", 16'h9012);

        // Right fill, 0 -> 9 wrap at entry.
        do_reset();
        dir = 1'b0;
        for (int s = 0; s < 12; s++) begin
            cyc(T);
            lit("right_fill", seq_r[s]);
        end

        // Paused single steps, prescaler held, step ignored while running.
        do_reset();
        enable = 1'b0; dir = 1'b1;
        for (int s = 0; s < 3; s++) begin
            cyc(4);
            step = 1'b1;
            cyc(1);
            step = 1'b0;
            lit("step", seq_l[s]);
            chk("step_tick", {31'h0, tick4}, 32'h1);
        end
        enable = 1'b1; step = 1'b1;
        cyc(2);
        lit("step_ignored", 16'hF012);
        cyc(1);
        step = 1'b0;
        lit("resume", 16'h0123);

        // Direction reversal mid-scroll.
        do_reset();
        dir = 1'b1;
        cyc(4 * T);
        lit("rev_start", 16'h0123);
        dir = 1'b0;
        cyc(T); lit("rev_r1", 16'h9012);
        cyc(T); lit("rev_r2", 16'h8901);
        dir = 1'b1;
        cyc(T); lit("rev_l1", 16'h9012);
        cyc(T); lit("rev_l2", 16'h0123);

        // Clear, then reset, landing on the terminal-count cycle.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            dir = 1'b1;
            cyc(8 * T);
            lit("pre_clear", 16'h4567);
            cyc(T - 1);
            if (r == 0) clear = 1'b1; else reset = 1'b1;
            cyc(1);
            clear = 1'b0; reset = 1'b0;
            lit("cleared", 16'hFFFF);
            chk("clear_no_tick", {31'h0, tick4}, 32'h0);
            cyc(T - 1);
            lit("clear_hold", 16'hFFFF);
            cyc(1);
            lit("clear_refill", 16'hFFF0);
        end

        // Randomized soak against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            step   = ($urandom_range(0, 2) == 0);
            clear  = ($urandom_range(0, 60) == 0);
            reset  = ($urandom_range(0, 250) == 0);
            cyc(1);
        end
        reset = 1'b0; clear = 1'b0; step = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
